// File: rtl/matrix_keyboard_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the
// matrix keyboard AXI4-Lite register block.
package matrix_keyboard_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DIV  = 2'd1;
  localparam logic [1:0] REG_KEY  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_keyboard_axil_wr.sv
// AXI4-Lite write path: joins AW and W (in either order), issues a one-cycle
// register write strobe and drives the B channel.
module matrix_keyboard_axil_wr
  import matrix_keyboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  awidx,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        wr_en,
  output logic [1:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb
);

  wr_state_e   state;
  logic        aw_held;
  logic        w_held;
  logic [1:0]  idx_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        aw_hs;
  logic        w_hs;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Write fires as soon as both halves are present, including a live handshake.
  assign wr_en   = (state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_idx  = aw_held ? idx_q : awidx;
  assign wr_data = w_held ? data_q : wdata;
  assign wr_strb = w_held ? strb_q : wstrb;
  assign bresp   = RESP_OKAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        W_IDLE: begin
          if (wr_en) begin
            state   <= W_RESP;
            bvalid  <= 1'b1;
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              idx_q   <= awidx;
            end
            if (w_hs) begin
              w_held <= 1'b1;
              data_q <= wdata;
              strb_q <= wstrb;
            end
            awready <= ~(aw_held | aw_hs);
            wready  <= ~(w_held | w_hs);
          end
        end
        W_RESP: begin
          if (bready) begin
            state   <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/matrix_keyboard_axil_regs.sv
// AXI4-Lite register file for the matrix keyboard: CTRL, SCAN_DIV, KEYCODE and
// STATUS, with key-event capture from the scan core and a level interrupt.
module matrix_keyboard_axil_regs
  import matrix_keyboard_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            key_event,
  input  logic [7:0]                      key_code,
  output logic [31:0]                     ctrl_o,
  output logic [31:0]                     scan_div_o,
  output logic                            irq
);

  logic [31:0] ctrl_q;
  logic [31:0] div_q;
  logic [31:0] key_q;
  logic [31:0] stat_q;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] rd_mux;
  rd_state_e   rd_state;
  logic        unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr, s00_axi_araddr};

  matrix_keyboard_axil_wr u_wr (
    .clk     (s00_axi_aclk),
    .rst     (s00_axi_areset),
    .awidx   (s00_axi_awaddr[3:2]),
    .awvalid (s00_axi_awvalid),
    .awready (s00_axi_awready),
    .wdata   (s00_axi_wdata),
    .wstrb   (s00_axi_wstrb),
    .wvalid  (s00_axi_wvalid),
    .wready  (s00_axi_wready),
    .bresp   (s00_axi_bresp),
    .bvalid  (s00_axi_bvalid),
    .bready  (s00_axi_bready),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ctrl_q <= '0;
      div_q  <= '0;
      key_q  <= '0;
      stat_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en) begin
        unique case (wr_idx)
          REG_CTRL: ctrl_q <= merge_strb(ctrl_q, wr_data, wr_strb);
          REG_DIV:  div_q  <= merge_strb(div_q, wr_data, wr_strb);
          REG_KEY:  key_q  <= merge_strb(key_q, wr_data, wr_strb);
          REG_STAT: stat_q <= merge_strb(stat_q, wr_data, wr_strb);
          default:  ;
        endcase
      end
      // Later assignments let a coincident key event override the software write.
      if (key_event) begin
        key_q      <= {24'h0, key_code};
        stat_q[31] <= 1'b1;
      end
      irq <= ctrl_q[0] & stat_q[31];
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (s00_axi_araddr[3:2])
      REG_CTRL: rd_mux = ctrl_q;
      REG_DIV:  rd_mux = div_q;
      REG_KEY:  rd_mux = key_q;
      REG_STAT: rd_mux = stat_q;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rd_state        <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s00_axi_arvalid && s00_axi_arready) begin
            rd_state        <= R_DATA;
            s00_axi_rdata   <= rd_mux;
            s00_axi_rvalid  <= 1'b1;
            s00_axi_arready <= 1'b0;
          end else begin
            s00_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            rd_state        <= R_IDLE;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_arready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign s00_axi_rresp = RESP_OKAY;
  assign ctrl_o        = ctrl_q;
  assign scan_div_o    = div_q;

endmodule
